// File: rtl/sysbus_mem_responder.sv
// Memory slave (2**ADDR_W x 16) on a multiplexed tristate system bus with Ale/nOE/nWE strobes.
// Define SYSBUS_MEM_WAIT_EN to insert WAIT_STATES wait cycles per access; otherwise every access completes in 1 cycle.
module sysbus_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clock,
  input  logic        nReset,
  inout  wire  [15:0] SysBus,
  input  logic        Ale,
  input  logic        nOE,
  input  logic        nWE,
  output logic        Ready,
  output logic        BusErr
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RD_WAIT,
    RD_DRIVE,
    WR_WAIT,
    WR_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       rd_data;
  logic [15:0]       mem [2**ADDR_W];

  logic addr_load;
  logic err_next;
  logic rd_load;
  logic mem_we;
  logic wait_done;

`ifdef SYSBUS_MEM_WAIT_EN
  logic [3:0] wait_cnt;

  assign wait_done = (wait_cnt == 4'd0);

  // Loaded on the strobe-sampling edge, then counts down while an access is pending.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      wait_cnt <= 4'd0;
    end else if (state == ARMED && (state_next == RD_WAIT || state_next == WR_WAIT)) begin
      wait_cnt <= 4'(WAIT_STATES);
    end else if ((state == RD_WAIT || state == WR_WAIT) && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end
`else
  assign wait_done = 1'b1;
`endif

  always_comb begin
    state_next = state;
    addr_load  = 1'b0;
    err_next   = 1'b0;
    rd_load    = 1'b0;
    mem_we     = 1'b0;
    unique case (state)
      IDLE: begin
        if (Ale) begin
          addr_load  = 1'b1;
          state_next = ARMED;
        end else if (!nOE || !nWE) begin
          err_next = 1'b1;
        end
      end
      ARMED: begin
        if (Ale) begin
          addr_load = 1'b1;
        end else if (!nOE && !nWE) begin
          err_next = 1'b1;
        end else if (!nOE) begin
          state_next = RD_WAIT;
        end else if (!nWE) begin
          state_next = WR_WAIT;
        end
      end
      // A strobe released before the access completes wins over completion.
      RD_WAIT: begin
        if (nOE) begin
          err_next   = 1'b1;
          state_next = ARMED;
        end else if (wait_done) begin
          rd_load    = 1'b1;
          state_next = RD_DRIVE;
        end
      end
      WR_WAIT: begin
        if (nWE) begin
          err_next   = 1'b1;
          state_next = ARMED;
        end else if (wait_done) begin
          mem_we     = 1'b1;
          state_next = WR_DONE;
        end
      end
      RD_DRIVE: begin
        if (Ale) begin
          addr_load  = 1'b1;
          state_next = ARMED;
        end else if (nOE) begin
          state_next = ARMED;
        end
      end
      WR_DONE: begin
        if (Ale) begin
          addr_load  = 1'b1;
          state_next = ARMED;
        end else if (nWE) begin
          state_next = ARMED;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state    <= IDLE;
      addr_reg <= '0;
      rd_data  <= 16'h0000;
      Ready    <= 1'b0;
      BusErr   <= 1'b0;
    end else begin
      state  <= state_next;
      Ready  <= (state_next == RD_DRIVE) || (state_next == WR_DONE);
      BusErr <= err_next;
      if (addr_load) begin
        addr_reg <= SysBus[ADDR_W-1:0];
      end
      if (rd_load) begin
        rd_data <= mem[addr_reg];
      end
    end
  end

  // Storage has no reset; a reset edge suppresses any write pending on it.
  always_ff @(posedge Clock) begin
    if (nReset && mem_we) begin
      mem[addr_reg] <= SysBus;
    end
  end

  assign SysBus = (state == RD_DRIVE && !nOE) ? rd_data : 16'bz;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Self-checking bench for sysbus_mem_responder: directed bus scenarios followed by random
// transactions checked against a transaction-level memory model.
module tb_sysbus_mem_responder;

   localparam int ADDR_W      = 8;
   localparam int WAIT_STATES = 2;
`ifdef SYSBUS_MEM_WAIT_EN
   localparam int LAT = WAIT_STATES + 1;
`else
   localparam int LAT = 1;
`endif
   localparam int BOUND = 40;
   localparam logic [15:0] RELEASED = 16'hFFFF;

   logic Clock = 1'b0;
   logic nReset;
   logic Ale;
   logic nOE;
   logic nWE;
   logic Ready;
   logic BusErr;
   wire [15:0] SysBus;
   logic [15:0] busDrive;
   logic busEn;

   int errorCount = 0;
   int checkCount = 0;

   logic [15:0] refMem [2**ADDR_W];
   bit refValid [2**ADDR_W];
   int modelAddr;
   bit modelArmed;

   // The bench drives the bus only while the responder must not; a released bus floats high.
   assign SysBus = busEn ? busDrive : 16'bz;
   for (genvar i = 0; i < 16; i++) begin : g_pull
      pullup (SysBus[i]);
   end

   always #5 Clock = ~Clock;

   sysbus_mem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(WAIT_STATES)) dut (
      .Clock(Clock),
      .nReset(nReset),
      .SysBus(SysBus),
      .Ale(Ale),
      .nOE(nOE),
      .nWE(nWE),
      .Ready(Ready),
      .BusErr(BusErr)
   );

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic applyAle(input logic [15:0] busVal);
      busEn = 1'b1;
      busDrive = busVal;
      Ale = 1'b1;
      nWE = 1'($urandom_range(0, 1));
      tick();
      Ale = 1'b0;
      nWE = 1'b1;
      checkOutput("ale_buserr", 16'(BusErr), 16'h0);
      checkOutput("ale_ready", 16'(Ready), 16'h0);
      modelArmed = 1'b1;
      modelAddr = int'(busVal[ADDR_W-1:0]);
   endtask

   task automatic applyWrite(input logic [15:0] data);
      int n = 0;
      bit sawErr = 1'b0;
      busEn = 1'b1;
      busDrive = data;
      nWE = 1'b0;
      do begin
         tick();
         n++;
         if (BusErr) sawErr = 1'b1;
      end while (!Ready && n < BOUND);
      checkOutput("wr_latency", 16'(n), 16'(LAT + 1));
      checkOutput("wr_buserr", 16'(sawErr), 16'h0);
      nWE = 1'b1;
      busEn = 1'b0;
      tick();
      checkOutput("wr_ready_drop", 16'(Ready), 16'h0);
      refMem[modelAddr] = data;
      refValid[modelAddr] = 1'b1;
   endtask

   task automatic applyRead();
      int n = 0;
      busEn = 1'b0;
      nOE = 1'b0;
      do begin
         tick();
         n++;
      end while (!Ready && n < BOUND);
      checkOutput("rd_latency", 16'(n), 16'(LAT + 1));
      if (refValid[modelAddr]) checkOutput("rd_data", SysBus, refMem[modelAddr]);
      tick();
      if (refValid[modelAddr]) checkOutput("rd_hold", SysBus, refMem[modelAddr]);
      checkOutput("rd_ready_hold", 16'(Ready), 16'h1);
      nOE = 1'b1;
      tick();
      checkOutput("rd_release", SysBus, RELEASED);
      checkOutput("rd_ready_drop", 16'(Ready), 16'h0);
   endtask

   task automatic applyBoth();
      busEn = 1'b1;
      busDrive = 16'($urandom_range(0, 16'hFFFE));
      nOE = 1'b0;
      nWE = 1'b0;
      tick();
      checkOutput("both_buserr", 16'(BusErr), 16'h1);
      checkOutput("both_ready", 16'(Ready), 16'h0);
      nOE = 1'b1;
      nWE = 1'b1;
      tick();
      checkOutput("both_buserr_end", 16'(BusErr), 16'h0);
   endtask

   task automatic applyAbort(input bit isWrite, input int hold);
      bit sawEarly = 1'b0;
      busEn = isWrite;
      busDrive = ~refMem[modelAddr];
      if (isWrite) nWE = 1'b0;
      else nOE = 1'b0;
      repeat (hold + 1) begin
         tick();
         if (Ready || BusErr) sawEarly = 1'b1;
      end
      nOE = 1'b1;
      nWE = 1'b1;
      tick();
      checkOutput("abort_early", 16'(sawEarly), 16'h0);
      checkOutput("abort_buserr", 16'(BusErr), 16'h1);
      checkOutput("abort_ready", 16'(Ready), 16'h0);
      busEn = 1'b0;
      tick();
      checkOutput("abort_buserr_end", 16'(BusErr), 16'h0);
   endtask

   task automatic applyIdleStrobe(input bit useRead);
      busEn = 1'b0;
      if (useRead) nOE = 1'b0;
      else nWE = 1'b0;
      tick();
      checkOutput("idle_buserr1", 16'(BusErr), 16'h1);
      tick();
      checkOutput("idle_buserr2", 16'(BusErr), 16'h1);
      checkOutput("idle_ready", 16'(Ready), 16'h0);
      nOE = 1'b1;
      nWE = 1'b1;
      tick();
      checkOutput("idle_buserr_end", 16'(BusErr), 16'h0);
   endtask

   task automatic applyReset();
      nReset = 1'b0;
      nOE = 1'b1;
      nWE = 1'b1;
      Ale = 1'b0;
      busEn = 1'b0;
      tick();
      checkOutput("rst_ready", 16'(Ready), 16'h0);
      checkOutput("rst_buserr", 16'(BusErr), 16'h0);
      checkOutput("rst_bus", SysBus, RELEASED);
      nReset = 1'b1;
      modelArmed = 1'b0;
   endtask

   task automatic applyStimulus();
      int n;
      logic [15:0] d;

      applyReset();
      applyIdleStrobe(1'b0);

      applyAle(16'h0005);
      applyWrite(16'hBEEF);
      applyAle(16'h0005);
      applyRead();

      applyBoth();
      applyRead();

      applyAbort(1'b1, (LAT > 1) ? 1 : 0);
      applyRead();
      applyAbort(1'b0, LAT - 1);

      // Reset while the responder is driving the bus.
      nOE = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!Ready && n < BOUND);
      checkOutput("rdrive_data", SysBus, 16'hBEEF);
      nReset = 1'b0;
      tick();
      checkOutput("rdrive_rst_bus", SysBus, RELEASED);
      checkOutput("rdrive_rst_ready", 16'(Ready), 16'h0);
      nReset = 1'b1;
      nOE = 1'b1;
      modelArmed = 1'b0;
      applyIdleStrobe(1'b1);
      applyAle(16'h0005);
      applyRead();

      applyAle(16'hFF07);
      applyWrite(16'h0A55);
      applyAle(16'h0007);
      applyRead();
      applyAle(16'h3C05);
      applyRead();

      // Reset landing on a pending write must leave the location untouched.
      applyAle(16'h0007);
      busEn = 1'b1;
      busDrive = 16'h1111;
      nWE = 1'b0;
      tick();
      applyReset();
      applyAle(16'h0007);
      applyRead();

      for (int i = 0; i < 200; i++) begin
         int op = $urandom_range(0, 9);
         if (op <= 2 || (!modelArmed && op != 9)) begin
            d = {8'($urandom), 4'h0, 4'($urandom)};
            applyAle(d);
         end
         if (op == 3 || op == 4) applyWrite(16'($urandom_range(0, 16'hFFFE)));
         else if (op == 5 || op == 6) applyRead();
         else if (op == 7) applyBoth();
         else if (op == 8) applyAbort(1'($urandom_range(0, 1)), $urandom_range(0, LAT - 1));
         else if (op == 9 && $urandom_range(0, 3) == 0) applyReset();
      end
   endtask

   initial begin
      nReset = 1'b0;
      Ale = 1'b0;
      nOE = 1'b1;
      nWE = 1'b1;
      busEn = 1'b0;
      busDrive = 16'h0000;
      modelArmed = 1'b0;
      modelAddr = 0;
      for (int i = 0; i < 2**ADDR_W; i++) begin
         refMem[i] = 16'h0000;
         refValid[i] = 1'b0;
      end
      tick();
      applyStimulus();
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/sysbus_mem_responder.md
SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning word-address width (storage depth 2**ADDR_W x 16 bits).
REQ-002 SHALL have parameter WAIT_STATES, default 2, meaning extra wait cycles per access (range 0-15).
REQ-003 SHALL have port Clock, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port nReset, input, 1, meaning reset that is synchronous and active-low.
REQ-005 SHALL have port SysBus, inout, 16, meaning the shared tristate system bus.
REQ-006 SHALL have port Ale, input, 1, meaning the address latch enable: SysBus carries an address this cycle.
REQ-007 SHALL have port nOE, input, 1, meaning the read strobe, active-low.
REQ-008 SHALL have port nWE, input, 1, meaning the write strobe, active-low.
REQ-009 SHALL have port Ready, output, 1, meaning the access-complete indication.
REQ-010 SHALL have port BusErr, output, 1, meaning a one-cycle protocol-error pulse.

Function
REQ-011 SHALL implement states IDLE, ARMED, RD_WAIT, RD_DRIVE, WR_WAIT, WR_DONE.
REQ-012 SHALL, on any edge with Ale=1 in IDLE, ARMED, RD_DRIVE or WR_DONE, latch SysBus[ADDR_W-1:0] into AddrReg (upper bits ignored), go to ARMED, and ignore both strobes that cycle.
REQ-013 SHALL ignore Ale in RD_WAIT and WR_WAIT.
REQ-014 SHALL, in ARMED with nOE=0 and nWE=1, load WaitCnt=WAIT_STATES and go to RD_WAIT.
REQ-015 SHALL, in ARMED with nWE=0 and nOE=1, load WaitCnt=WAIT_STATES and go to WR_WAIT.
REQ-016 SHALL, in ARMED with nOE=0 and nWE=0, pulse BusErr for one cycle, remain in ARMED, and perform no access.
REQ-017 SHALL, in RD_WAIT or WR_WAIT, decrement WaitCnt each cycle while WaitCnt is non-zero, and act at WaitCnt=0.
REQ-018 SHALL, in RD_WAIT at WaitCnt=0, register mem[AddrReg] into RdData and go to RD_DRIVE.
REQ-019 SHALL, in RD_DRIVE, drive SysBus=RdData combinationally while nOE=0, and release SysBus to high-Z otherwise.
REQ-020 SHALL, in WR_WAIT at WaitCnt=0, write the current SysBus value to mem[AddrReg] and go to WR_DONE.
REQ-021 SHALL drive SysBus in no state other than RD_DRIVE.
REQ-022 SHALL make Ready a registered output equal to 1 exactly in RD_DRIVE and WR_DONE; read/write latency is WAIT_STATES+1 cycles from the edge that samples the strobe low.
REQ-023 SHALL return RD_DRIVE to ARMED when nOE=1, and WR_DONE to ARMED when nWE=1; AddrReg is retained so repeated accesses to the same address need no new Ale.
REQ-024 SHALL, if the active strobe deasserts in RD_WAIT or WR_WAIT, abort: go to ARMED, perform no write, keep Ready=0, and pulse BusErr.
REQ-025 SHALL, on a strobe asserted in IDLE (no address latched), pulse BusErr and stay in IDLE.

Reset
REQ-026 SHALL, on a clock edge with nReset=0, set state IDLE, AddrReg=0, WaitCnt=0, RdData=0, Ready=0, BusErr=0, with SysBus released, regardless of the current state.
REQ-027 SHALL NOT clear storage contents on reset; a write aborted by reset leaves its location unchanged.

Configuration
REQ-028 SHALL honour WAIT_STATES when macro SYSBUS_MEM_WAIT_EN is defined.
REQ-029 SHALL, when SYSBUS_MEM_WAIT_EN is undefined, omit WaitCnt logic, treat WAIT_STATES as 0, and give latency 1 cycle; all other behaviour is unchanged.

Verification
REQ-030 SHALL cover: write, WAIT_STATES=2: Ale with bus 0x0005, then nWE=0 with bus 0xBEEF -> Ready=1 on the 3rd edge after nWE is sampled, and mem[5]=0xBEEF.
REQ-031 SHALL cover: read-back: Ale 0x0005, then nOE=0 -> SysBus=0xBEEF with Ready=1 after 3 cycles; SysBus returns to Z one cycle after nOE=1.
REQ-032 SHALL cover: nOE=0 and nWE=0 together in ARMED -> BusErr pulses once, no write, Ready=0.
REQ-033 SHALL cover: nWE deasserted after 1 wait cycle -> abort, BusErr=1, mem[AddrReg] unchanged.
REQ-034 SHALL cover: nReset=0 during RD_DRIVE -> next edge SysBus=Z, Ready=0, state IDLE; a subsequent read of address 5 still returns 0xBEEF.
REQ-035 SHALL cover: Ale with bus 0xFF07, ADDR_W=8 -> AddrReg=0x07; build without SYSBUS_MEM_WAIT_EN -> Ready one cycle after the strobe.
